// File: rtl/idma_reg32_3d_launcher.sv
// Register-interface initiator: programs an idma_reg32_3d frontend from a 3D job handshake and returns the ID.
// Optional macro IDMA_REG32_3D_LAUNCHER_POLL_EN: poll done_id until the launched transfer has completed.
package idma_reg32_3d_launcher_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg32_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg32_rsp_t;

    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [31:0] length;
        logic [11:0] conf;
        logic [31:0] src_stride2;
        logic [31:0] dst_stride2;
        logic [31:0] reps2;
        logic [31:0] src_stride3;
        logic [31:0] dst_stride3;
        logic [31:0] reps3;
    } job_t;

endpackage

module idma_reg32_3d_launcher #(
    parameter int unsigned NumStreams  = 1,
    parameter int unsigned StreamWidth = (NumStreams > 1) ? $clog2(NumStreams) : 1,
    parameter type         reg_req_t   = idma_reg32_3d_launcher_pkg::reg32_req_t,
    parameter type         reg_rsp_t   = idma_reg32_3d_launcher_pkg::reg32_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   job_valid_i,
    output logic                   job_ready_o,
    input  logic [31:0]            src_addr_i,
    input  logic [31:0]            dst_addr_i,
    input  logic [31:0]            length_i,
    input  logic [11:0]            conf_i,
    input  logic [31:0]            src_stride2_i,
    input  logic [31:0]            dst_stride2_i,
    input  logic [31:0]            reps2_i,
    input  logic [31:0]            src_stride3_i,
    input  logic [31:0]            dst_stride3_i,
    input  logic [31:0]            reps3_i,
    input  logic [StreamWidth-1:0] stream_i,
    output reg_req_t               reg_req_o,
    input  reg_rsp_t               reg_rsp_i,
    output logic [31:0]            id_o,
    output logic                   id_valid_o,
    output logic                   err_o,
    output logic                   busy_o
);

    localparam int unsigned IdxW  = 4;
    localparam int unsigned DataW = 32;

`ifdef IDMA_REG32_3D_LAUNCHER_POLL_EN
    typedef enum logic [2:0] {IDLE, WRITE, LAUNCH, POLL, ERR} state_e;
`else
    typedef enum logic [2:0] {IDLE, WRITE, LAUNCH, ERR} state_e;
`endif

    state_e                                state_q;
    logic [IdxW-1:0]                       idx_q;
    idma_reg32_3d_launcher_pkg::job_t      job_q;
    logic [StreamWidth-1:0]                stream_q;
    reg_req_t                              req_q;
    logic [31:0]                           id_q;
    logic                                  id_valid_q;
    logic                                  err_q;
    logic                                  job_ready_q;
    logic                                  busy_q;

    logic [IdxW-1:0]  last_idx;
    logic [DataW-1:0] wr_addr;
    logic [DataW-1:0] wr_data;
    logic [DataW-1:0] stream_ofs;
    logic [DataW-1:0] next_id_addr;
`ifdef IDMA_REG32_3D_LAUNCHER_POLL_EN
    logic [DataW-1:0] done_id_addr;
`endif

    // Last write index: enable_nd=3 behaves like enable_nd=2.
    always_comb begin
        last_idx = IdxW'(3);
        if (job_q.conf[11:10] == 2'd1) begin
            last_idx = IdxW'(6);
        end else if (job_q.conf[11]) begin
            last_idx = IdxW'(9);
        end
    end

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        case (idx_q)
            4'd0: begin wr_addr = 32'h0000_0000; wr_data = DataW'(job_q.conf);  end
            4'd1: begin wr_addr = 32'h0000_00D0; wr_data = job_q.dst_addr;      end
            4'd2: begin wr_addr = 32'h0000_00D8; wr_data = job_q.src_addr;      end
            4'd3: begin wr_addr = 32'h0000_00E0; wr_data = job_q.length;        end
            4'd4: begin wr_addr = 32'h0000_00E8; wr_data = job_q.dst_stride2;   end
            4'd5: begin wr_addr = 32'h0000_00F0; wr_data = job_q.src_stride2;   end
            4'd6: begin wr_addr = 32'h0000_00F8; wr_data = job_q.reps2;         end
            4'd7: begin wr_addr = 32'h0000_0100; wr_data = job_q.dst_stride3;   end
            4'd8: begin wr_addr = 32'h0000_0108; wr_data = job_q.src_stride3;   end
            4'd9: begin wr_addr = 32'h0000_0110; wr_data = job_q.reps3;         end
            default: begin wr_addr = '0; wr_data = '0; end
        endcase
    end

    assign stream_ofs   = DataW'({stream_q, 2'b00});
    assign next_id_addr = 32'h0000_0044 + stream_ofs;
`ifdef IDMA_REG32_3D_LAUNCHER_POLL_EN
    assign done_id_addr = 32'h0000_0084 + stream_ofs;
`endif

    // Each access: one cycle to raise valid, then hold until ready; one request outstanding at most.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            job_q       <= '0;
            stream_q    <= '0;
            req_q       <= '0;
            id_q        <= '0;
            id_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            id_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (job_valid_i) begin
                        job_q <= '{src_addr:    src_addr_i,
                                   dst_addr:    dst_addr_i,
                                   length:      length_i,
                                   conf:        conf_i,
                                   src_stride2: src_stride2_i,
                                   dst_stride2: dst_stride2_i,
                                   reps2:       reps2_i,
                                   src_stride3: src_stride3_i,
                                   dst_stride3: dst_stride3_i,
                                   reps3:       reps3_i};
                        stream_q    <= stream_i;
                        idx_q       <= '0;
                        job_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= WRITE;
                    end
                end
                WRITE: begin
                    if (!req_q.valid) begin
                        req_q.valid <= 1'b1;
                        req_q.write <= 1'b1;
                        req_q.addr  <= wr_addr;
                        req_q.wdata <= wr_data;
                        req_q.wstrb <= 4'hF;
                    end else if (reg_rsp_i.ready) begin
                        req_q.valid <= 1'b0;
                        if (reg_rsp_i.error) begin
                            err_q   <= 1'b1;
                            state_q <= ERR;
                        end else if (idx_q == last_idx) begin
                            state_q <= LAUNCH;
                        end else begin
                            idx_q <= idx_q + IdxW'(1);
                        end
                    end
                end
                LAUNCH: begin
                    if (!req_q.valid) begin
                        req_q.valid <= 1'b1;
                        req_q.write <= 1'b0;
                        req_q.addr  <= next_id_addr;
                        req_q.wdata <= '0;
                        req_q.wstrb <= 4'h0;
                    end else if (reg_rsp_i.ready) begin
                        req_q.valid <= 1'b0;
                        if (reg_rsp_i.error) begin
                            err_q   <= 1'b1;
                            state_q <= ERR;
                        end else begin
                            id_q <= reg_rsp_i.rdata;
`ifdef IDMA_REG32_3D_LAUNCHER_POLL_EN
                            state_q <= POLL;
`else
                            id_valid_q  <= 1'b1;
                            job_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
`endif
                        end
                    end
                end
`ifdef IDMA_REG32_3D_LAUNCHER_POLL_EN
                POLL: begin
                    if (!req_q.valid) begin
                        req_q.valid <= 1'b1;
                        req_q.write <= 1'b0;
                        req_q.addr  <= done_id_addr;
                        req_q.wdata <= '0;
                        req_q.wstrb <= 4'h0;
                    end else if (reg_rsp_i.ready) begin
                        req_q.valid <= 1'b0;
                        if (reg_rsp_i.error) begin
                            err_q   <= 1'b1;
                            state_q <= ERR;
                        end else if (reg_rsp_i.rdata == id_q) begin
                            id_valid_q  <= 1'b1;
                            job_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
`endif
                ERR: begin
                    job_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    req_q.valid <= 1'b0;
                    job_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign reg_req_o   = req_q;
    assign id_o        = id_q;
    assign id_valid_o  = id_valid_q;
    assign err_o       = err_q;
    assign job_ready_o = job_ready_q;
    assign busy_o      = busy_q;

endmodule

// File: doc/idma_reg32_3d_launcher.md
Name: idma_reg32_3d_launcher

Overview:
- Register-interface initiator that programs one idma_reg32_3d register port from a job handshake.
- Accepts a 3D job (addresses, length, conf, strides, reps) and issues the register writes in sequence.
- Launches the job by reading next_id of the selected stream and returns the captured transfer ID.
- Sits in accelerator/cluster glue in place of a core driving the DMA frontend by software.

Parameters:
- NumStreams, 1, streams in the target frontend (max 16)
- StreamWidth, idx_width(NumStreams), stream index width
- reg_req_t, logic, register_interface request type (addr, write, wdata, wstrb, valid)
- reg_rsp_t, logic, register_interface response type (rdata, error, ready)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- job_valid_i  in  1  job request valid
- job_ready_o  out  1  job accepted when valid&&ready
- src_addr_i / dst_addr_i / length_i  in  32 each  1D transfer fields
- conf_i  in  12  conf register image: [0] decouple_aw, [1] decouple_rw, [2] src_reduce_len, [3] dst_reduce_len, [6:4] src_max_llen, [9:7] dst_max_llen, [11:10] enable_nd
- src_stride2_i / dst_stride2_i / reps2_i / src_stride3_i / dst_stride3_i / reps3_i  in  32 each  ND fields
- stream_i  in  StreamWidth  target stream
- reg_req_o  out  reg_req_t  register master request
- reg_rsp_i  in  reg_rsp_t  register master response
- id_o  out  32  transfer ID read from next_id
- id_valid_o  out  1  one-cycle pulse, id_o valid
- err_o  out  1  one-cycle pulse, job aborted on error response
- busy_o  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset: FSM IDLE; job_ready_o=1; reg_req_o.valid=0; id_o=0; id_valid_o=0; err_o=0; busy_o=0.
- Job capture: on job_valid_i&&job_ready_o all job fields and stream_i are registered; job_ready_o=0 until return to IDLE. Inputs are ignored after capture.
- Register map (byte offsets, 32-bit, wstrb=4'hF):
  - conf 0x00
  - next_id[c] 0x44+4c; done_id[c] 0x84+4c
  - dst_addr 0xD0, src_addr 0xD8, length 0xE0
  - dst_stride_2 0xE8, src_stride_2 0xF0, reps_2 0xF8
  - dst_stride_3 0x100, src_stride_3 0x108, reps_3 0x110
- FSM: IDLE -> WRITE -> LAUNCH -> (POLL if enabled) -> IDLE; any error -> ERR -> IDLE.
- WRITE: 4-bit index walks conf, dst_addr, src_addr, length, [dim-2 triple], [dim-3 triple].
  - Dim-2 writes are skipped when enable_nd=0.
  - Dim-3 writes are skipped when enable_nd<2 (enable_nd=3 is treated as 2).
  - Exactly one outstanding request. valid, addr, write and wdata are stable from assertion until the cycle valid&&ready.
  - The index advances in the cycle valid&&ready; valid is re-asserted in the next cycle (minimum 2 cycles per access).
- LAUNCH: read (write=0, wdata=0) of next_id[stream]. The frontend may hold ready low for arbitrary time (arbitration backpressure); the request stays held.
  - On ready: id_o<=rdata, id_valid_o pulses the following cycle.
- Error: reg_rsp_i.error sampled with ready in any access -> ERR (err_o=1 one cycle) -> IDLE. No further accesses for that job; id_valid_o is not pulsed.
- Latency: 1D job with zero-wait responses: accept to id_valid_o = 10 cycles; 2D = 16; 3D = 22.
- Reset mid-operation clears state immediately. An in-flight register request is dropped (valid=0); the slave side must tolerate this.

Optional Feature:
- IDMA_REG32_3D_LAUNCHER_POLL_EN
- Defined: after LAUNCH the FSM enters POLL instead of IDLE.
  - It reads done_id[stream] repeatedly, re-reading the cycle after each completed read.
  - Leaves POLL when rdata==captured id.
  - id_valid_o then pulses at completion instead of at launch, so busy_o spans the whole transfer.
  - An error response during POLL goes to ERR.
- Undefined: POLL state and logic are absent; id_valid_o pulses at launch.

Test Plan:
- 1D job, src=0x1000, dst=0x2000, len=0x40, conf=0, zero-wait slave -> writes exactly 0x00=0, 0xD0=0x2000, 0xD8=0x1000, 0xE0=0x40, then read 0x44; rdata 5 -> id_o=5, id_valid_o one pulse, 10 cycles after accept.
- 3D job, enable_nd=2, stream 1 of 2 -> 10 writes in map order, then read at 0x48; 2D job (enable_nd=1) -> 7 writes, none to 0x100-0x110.
- Slave holds ready low 50 cycles on next_id read -> reg_req_o stable all 50 cycles, job_ready_o=0, single id_valid_o after ready.
- error=1 on length write -> err_o pulse, no next_id read, job_ready_o=1 next cycle; next job runs normally.
- rst_ni asserted during dim-2 writes -> all outputs at reset values immediately; a fresh job restarts at the conf write.
- POLL_EN: next_id returns 7, done_id reads return 6,6,7 -> three done_id reads, then id_valid_o with id_o=7.
